uart_tx: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx_baud_counter.sv | 24 ++
 rtl/uart_tx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry and bit-period clamping.
// Frame length depends on UART_TX_PARITY_EN (even parity bit when defined).
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam logic [15:0] MIN_PERIOD           = 16'd2;
    localparam int unsigned FRAME_BITS_PARITY    = 11;
    localparam int unsigned FRAME_BITS_NO_PARITY = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // The receiver samples at P/2-1, so P must never drop below 2.
    function automatic logic [15:0] clamp_period(input logic [15:0] baud);
        return (baud < MIN_PERIOD) ? MIN_PERIOD : baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period counter: counts 0..period-1 while enabled, flags the last cycle.
module uart_tx_baud_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] period,
    output logic [15:0] count,
    output logic        tc
);

    assign tc = en && (count == period - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to include the even-parity bit (11-bit frame instead of 10).
module uart_tx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baudrate,
    uart_tx_if.slave    tx,
    output logic        dataline,
    output logic        busy,
    output logic        done
);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx;
    logic [15:0]          period;
    logic [15:0]          count;
    logic                 tc;
    logic                 cnt_en;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign accept = tx.data_valid && tx.data_ready;
    assign cnt_en = (state != IDLE);

    uart_tx_baud_counter u_baud (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .clr    (accept),
        .period (period),
        .count  (count),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_idx       <= '0;
            period        <= MIN_PERIOD;
            dataline      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            tx.data_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg     <= tx.data_in;
                        period        <= clamp_period(baudrate);
                        bit_idx       <= '0;
                        dataline      <= 1'b0;
                        busy          <= 1'b1;
                        tx.data_ready <= 1'b0;
                        state         <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit    <= ^tx.data_in;
`endif
                    end
                end
                START: begin
                    if (tc) begin
                        dataline <= shift_reg[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tc) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            dataline <= parity_bit;
                            state    <= PARITY;
`else
                            dataline <= 1'b1;
                            state    <= STOP;
`endif
                        end else begin
                            // Next bit is presented from shift_reg[1] so the line stays registered.
                            dataline  <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tc) begin
                        dataline <= 1'b1;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Set one cycle early so the registered pulse lands on the last stop cycle.
                    if (count == period - 16'd2) begin
                        done <= 1'b1;
                    end
                    if (tc) begin
                        busy          <= 1'b0;
                        tx.data_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    dataline      <= 1'b1;
                    busy          <= 1'b0;
                    tx.data_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
